// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/dispatch sequencer sitting above the datapath
// controller. It fetches one 16-bit word per instruction and decodes HALT
// locally. Every other word goes to the controller via exec_start/exec_waiting,
// and the sequencer waits for it to retire before fetching again.
// Optional feature: define INSTR_SEQ_COUNT_EN to enable the saturating
// retired-instruction counter on instr_count. Without it, instr_count is
// tied to zero.
module instr_sequencer #(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic              exec_waiting,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic              exec_start,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_DISPATCH = 3'd3,
    S_EXEC     = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  localparam logic [2:0] OP_HALT = 3'b111;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [15:0]       ir_reg;
  logic              fetch_done;
  logic              retire;

  // A fetch completes on the edge where memory returns data for our request.
  assign fetch_done = (state_reg == S_FETCH) && mem_ready;
  // The controller is back in WAIT after the start was taken, so the instruction is finished.
  assign retire     = (state_reg == S_EXEC) && exec_waiting;

  // State register. All strobes are decoded from this register, so the async reset clears them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next = state_reg;
    mem_rd     = 1'b0;
    exec_start = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        busy = 1'b1;
        if (ir_reg[15:13] == OP_HALT) state_next = S_HALT;
        else                          state_next = S_DISPATCH;
      end
      S_DISPATCH: begin
        exec_start = 1'b1;
        busy       = 1'b1;
        if (exec_waiting) state_next = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        // The controller drops exec_waiting in the first EXEC cycle, so this waits for completion.
        if (exec_waiting) state_next = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // PC and IR load together on the fetch-completion edge. The PC wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= ADDR_W'(RESET_PC);
      ir_reg <= 16'h0000;
    end else if (fetch_done) begin
      pc_reg <= pc_reg + ADDR_W'(1);
      ir_reg <= mem_rdata;
    end
  end

  assign pc       = pc_reg;
  assign mem_addr = pc_reg;
  assign ir       = ir_reg;

`ifdef INSTR_SEQ_COUNT_EN
  logic [15:0] count_reg;

  // Retired-instruction counter. It saturates at its maximum. HALT never reaches EXEC, so it is never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 16'h0000;
    end else if (retire && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'h0001;
    end
  end

  assign instr_count = count_reg;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instr_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer (ADDR_W=4 so the PC wrap is reachable).
// Components:
// - A behavioural memory with a programmable number of wait states.
// - A datapath-controller model that spends K=2 cycles outside WAIT per start.
// - A scoreboard of expected fetch addresses and dispatched IR words.
module tb_instr_sequencer;
  localparam int AW = 4;
  localparam int K  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [15:0]   mem_rdata;
  logic          mem_ready;
  logic          exec_waiting;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic          exec_start;
  logic          busy;
  logic          halted;
  logic [15:0]   instr_count;

  instr_sequencer #(.ADDR_W(AW), .RESET_PC(0)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .exec_waiting (exec_waiting),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .pc           (pc),
    .ir           (ir),
    .exec_start   (exec_start),
    .busy         (busy),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  logic [15:0]   prog [0:15];
  int            mem_wait = 0;
  int            ws = 0;
  int            k_cnt = 0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            start_cycles = 0;
  int            fetch_cyc = 0;
  logic [15:0]   exp_ir_q [$];
  logic [AW-1:0] exp_addr_q [$];

  // Memory model: combinational read; ready after mem_wait stall cycles.
  assign mem_rdata    = prog[mem_addr];
  assign mem_ready    = mem_rd && (ws >= mem_wait);
  assign exec_waiting = (k_cnt == 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_rd || mem_ready) ws <= 0;
    else                      ws <= ws + 1;
    if (rst)                             k_cnt <= 0;
    else if (exec_start && exec_waiting) k_cnt <= K;
    else if (k_cnt > 0)                  k_cnt <= k_cnt - 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations on fetch completion and on start acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (exec_start) start_cycles++;
      if (mem_rd && mem_ready) begin
        fetch_cyc = cyc;
        if (exp_addr_q.size() == 0) check_val("fetch_unexpected", 32'(mem_addr), 32'hFFFF);
        else                        check_val("fetch_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        $display("fetch  addr=%0d word=%h", mem_addr, mem_rdata);
      end
      if (exec_start && exec_waiting) begin
        if (exp_ir_q.size() == 0) check_val("dispatch_unexpected", 32'(ir), 32'hFFFFFFFF);
        else                      check_val("dispatch_ir", 32'(ir), 32'(exp_ir_q.pop_front()));
        $display("dispatch ir=%h pc=%0d", ir, pc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first_rd;
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    prog[0] = 16'hD105;
    prog[1] = 16'h1234;
    prog[2] = 16'h2345;
    prog[3] = 16'hE000;
    rst = 1'b1;
    run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_mem_rd", 32'(mem_rd), 0);
    check_val("rst_exec_start", 32'(exec_start), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_halted", 32'(halted), 0);
    check_val("rst_pc", 32'(pc), 0);
    check_val("rst_mem_addr", 32'(mem_addr), 0);
    check_val("rst_ir", 32'(ir), 0);
    check_val("rst_count", 32'(instr_count), 0);

    // First fetch: MOV_imm at address 0
    exp_addr_q.push_back(AW'(0));
    exp_ir_q.push_back(16'hD105);
    run = 1'b1;
    tick();
    check_val("first_rd", 32'(mem_rd), 1);
    check_val("first_addr", 32'(mem_addr), 0);
    first_rd = cyc;
    tick();
    check_val("mov_ir", 32'(ir), 32'hD105);
    check_val("mov_pc", 32'(pc), 1);

    // Next fetch is stalled by 3 cycles
    mem_wait = 3;
    exp_addr_q.push_back(AW'(1));
    exp_ir_q.push_back(16'h1234);
    n = 0;
    while (!mem_rd && n < 20) begin tick(); n++; end
    check_val("second_rd_seen", 32'(mem_rd), 1);
    check_val("instr_period", 32'(cyc - first_rd), 6);
    check_val("start_one_cycle", 32'(start_cycles), 1);
    for (int i = 0; i < 4; i++) begin
      check_val("stall_rd", 32'(mem_rd), 1);
      check_val("stall_addr", 32'(mem_addr), 1);
      check_val("stall_ir", 32'(ir), 32'hD105);
      tick();
    end
    check_val("stall_ir_loaded", 32'(ir), 32'h1234);
    check_val("stall_rd_done", 32'(mem_rd), 0);
    mem_wait = 0;

    // Drop run during EXEC; the instruction completes and the FSM parks in IDLE
    n = 0;
    while (!exec_start && n < 20) begin tick(); n++; end
    check_val("dispatch_seen", 32'(exec_start), 1);
    tick();
    run = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check_val("stop_busy", 32'(busy), 0);
    check_val("stop_pc", 32'(pc), 2);
    check_val("stop_start", 32'(exec_start), 0);
    tick();
    tick();
    check_val("stop_no_rd", 32'(mem_rd), 0);

    // Resume from the preserved PC, then run into HALT at address 3
    exp_addr_q.push_back(AW'(2));
    exp_ir_q.push_back(16'h2345);
    exp_addr_q.push_back(AW'(3));
    run = 1'b1;
    tick();
    check_val("resume_rd", 32'(mem_rd), 1);
    check_val("resume_addr", 32'(mem_addr), 2);
    n = 0;
    while (!halted && n < 40) begin tick(); n++; end
    check_val("halt_seen", 32'(halted), 1);
    check_val("halt_latency", 32'(cyc - fetch_cyc), 2);
    check_val("halt_pc", 32'(pc), 4);
    check_val("halt_ir", 32'(ir), 32'hE000);
    check_val("halt_no_start", 32'(start_cycles), 3);
    for (int i = 0; i < 6; i++) begin
      run = (i < 3) ? 1'b0 : 1'b1;
      tick();
    end
    check_val("halt_sticky", 32'(halted), 1);
    check_val("halt_no_rd", 32'(mem_rd), 0);
    check_val("halt_pc_hold", 32'(pc), 4);

    // Reset pulse takes effect asynchronously
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("arst_halted", 32'(halted), 0);
    check_val("arst_pc", 32'(pc), 0);
    check_val("arst_busy", 32'(busy), 0);
    run = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 16-word program covering every address, which exercises the PC wrap
    for (int i = 0; i < 16; i++) begin
      prog[i] = 16'h1000 + 16'(i * 16'h0111);
      exp_addr_q.push_back(AW'(i));
      exp_ir_q.push_back(prog[i]);
    end
    run = 1'b1;
    n = 0;
    while (!(mem_rd && mem_ready && mem_addr == AW'(15)) && n < 200) begin tick(); n++; end
    check_val("wrap_fetch15", 32'(mem_addr), 15);
    tick();
    check_val("wrap_pc", 32'(pc), 0);
    run = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check_val("wrap_idle", 32'(busy), 0);
    check_val("wrap_pc_idle", 32'(pc), 0);
    check_val("wrap_starts", 32'(start_cycles), 19);
`ifdef INSTR_SEQ_COUNT_EN
    check_val("instr_count", 32'(instr_count), 16);
`else
    check_val("instr_count", 32'(instr_count), 0);
`endif
    check_val("sb_ir_left", 32'(exp_ir_q.size()), 0);
    check_val("sb_addr_left", 32'(exp_addr_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
